// File: rtl/dsp_systolic_18x18u.sv
// Unsigned systolic multiply-accumulate chain: NUM lanes of ax*ay summed along a cascade,
// lane NUM-1 with PIPELINE register stages, each lower lane one cascade stage later.
module dsp_systolic_18x18u #(
  parameter string       FAMILY         = "Agilex",
  parameter int unsigned PIPELINE       = 3,
  parameter int unsigned AX_WIDTH       = 18,
  parameter int unsigned AY_WIDTH       = 18,
  parameter int unsigned NUM            = 4,
  parameter int unsigned RESULT_A_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AX_WIDTH-1:0]       ax [NUM],
  input  logic [AY_WIDTH-1:0]       ay [NUM],
  output logic [RESULT_A_WIDTH-1:0] result
);

  localparam int unsigned PW       = AX_WIDTH + AY_WIDTH;
  localparam int unsigned RW       = RESULT_A_WIDTH;
  // PIPELINE=2: one input stage; 3: two input stages; 4: two input stages plus product stage.
  localparam int unsigned InStages = (PIPELINE >= 3) ? 2 : 1;
  localparam bit          ProdReg  = (PIPELINE >= 4);

  logic [RW-1:0] chain [NUM];

  for (genvar i = 0; i < NUM; i++) begin : g_lane
    logic [AX_WIDTH-1:0] ax_q [InStages];
    logic [AY_WIDTH-1:0] ay_q [InStages];
    logic [PW-1:0]       mult;
    logic [PW-1:0]       prod;
    logic [RW-1:0]       chain_in;
    logic [RW-1:0]       c_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < InStages; s++) begin
          ax_q[s] <= '0;
          ay_q[s] <= '0;
        end
      end else begin
        ax_q[0] <= ax[i];
        ay_q[0] <= ay[i];
        for (int s = 1; s < InStages; s++) begin
          ax_q[s] <= ax_q[s-1];
          ay_q[s] <= ay_q[s-1];
        end
      end
    end

    assign mult = PW'(ax_q[InStages-1]) * PW'(ay_q[InStages-1]);

    if (ProdReg) begin : g_prod_reg
      logic [PW-1:0] prod_q;
      always_ff @(posedge clk) begin
        if (reset) prod_q <= '0;
        else       prod_q <= mult;
      end
      assign prod = prod_q;
    end else begin : g_prod_comb
      assign prod = mult;
    end

    // Lane 0 starts the cascade from zero.
    if (i == 0) begin : g_head
      assign chain_in = '0;
    end else begin : g_link
      assign chain_in = chain[i-1];
    end

    always_ff @(posedge clk) begin
      if (reset) c_q <= '0;
      else       c_q <= RW'(prod) + chain_in;
    end

    assign chain[i] = c_q;
  end

  assign result = chain[NUM-1];

endmodule

// File: tb/tb_dsp_systolic_18x18u.sv
// Scoreboard bench: three chain configurations share one stimulus stream; expected sums are
// pushed per cycle and a monitor compares them just after each rising edge.
module tb_dsp_systolic_18x18u;

  localparam logic [63:0] F = 64'd68718952449;  // (2^18-1)^2

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] ax_s [8];
  logic [17:0] ay_s [8];
  logic [17:0] ax_a [4];
  logic [17:0] ay_a [4];
  logic [17:0] ax_c [2];
  logic [17:0] ay_c [2];
  logic [63:0] res_a, res_b, res_c;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ax_a[i] = ax_s[i];
      ay_a[i] = ay_s[i];
    end
    for (int i = 0; i < 2; i++) begin
      ax_c[i] = ax_s[i];
      ay_c[i] = ay_s[i];
    end
  end

  dsp_systolic_18x18u u_dflt (
    .clk(clk), .reset(reset), .ax(ax_a), .ay(ay_a), .result(res_a)
  );

  dsp_systolic_18x18u #(.PIPELINE(2), .NUM(8)) u_p2n8 (
    .clk(clk), .reset(reset), .ax(ax_s), .ay(ay_s), .result(res_b)
  );

  dsp_systolic_18x18u #(.PIPELINE(4), .NUM(2)) u_p4n2 (
    .clk(clk), .reset(reset), .ax(ax_c), .ay(ay_c), .result(res_c)
  );

  typedef struct {
    bit          chk;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] ec;
  } exp_t;

  exp_t        sb_q [$];
  logic [63:0] hist [32][8];
  int          edge_n = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [63:0] model(input int num, input int l);
    logic [63:0] sum;
    int idx;
    sum = '0;
    for (int i = 0; i < num; i++) begin
      idx = edge_n - l - (num - 1 - i);
      sum += hist[((idx % 32) + 32) % 32][i];
    end
    return sum;
  endfunction

  // Called around a falling edge with ax_s/ay_s already set; covers the next rising edge.
  task automatic step(input bit rst, input bit chk, input bit use_hand, input logic [63:0] hand);
    exp_t e;
    reset = rst;
    edge_n++;
    if (rst) begin
      for (int k = 0; k < 32; k++)
        for (int i = 0; i < 8; i++) hist[k][i] = '0;
    end else begin
      for (int i = 0; i < 8; i++) hist[edge_n % 32][i] = 64'(ax_s[i]) * 64'(ay_s[i]);
    end
    e.chk = chk;
    e.ea  = use_hand ? hand : model(4, 2);
    e.eb  = model(8, 1);
    e.ec  = model(2, 3);
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_zero();
    for (int i = 0; i < 8; i++) begin
      ax_s[i] = '0;
      ay_s[i] = '0;
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < 8; i++) begin
      ax_s[i] = 18'($urandom_range(0, 18'h3FFFF));
      ay_s[i] = 18'($urandom_range(0, 18'h3FFFF));
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk) begin
          check("p3n4", res_a, e.ea);
          check("p2n8", res_b, e.eb);
          check("p4n2", res_c, e.ec);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  localparam logic [63:0] FsHand [8] = '{64'd0, 64'd0, F, 2 * F, 3 * F, 4 * F, 4 * F, 4 * F};

  initial begin : driver
    for (int k = 0; k < 32; k++)
      for (int i = 0; i < 8; i++) hist[k][i] = '0;
    set_rand();
    @(negedge clk);

    // Reset held two cycles under random inputs, then a short random run.
    for (int c = 0; c < 2; c++) begin
      set_rand();
      step(1'b1, 1'b1, 1'b1, 64'd0);
    end
    for (int c = 0; c < 6; c++) begin
      set_rand();
      step(1'b0, 1'b1, 1'b0, 64'd0);
    end
    set_zero();
    for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 1'b0, 64'd0);

    // Lane 3 impulse 3*5: appears two edges after sampling.
    ax_s[3] = 18'd3;
    ay_s[3] = 18'd5;
    step(1'b0, 1'b1, 1'b1, 64'd0);
    set_zero();
    step(1'b0, 1'b1, 1'b1, 64'd0);
    step(1'b0, 1'b1, 1'b1, 64'd15);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 1'b1, 64'd0);

    // Lane 0 impulse 7*7: appears five edges after sampling.
    ax_s[0] = 18'd7;
    ay_s[0] = 18'd7;
    step(1'b0, 1'b1, 1'b1, 64'd0);
    set_zero();
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b1, 64'd0);
    step(1'b0, 1'b1, 1'b1, 64'd49);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 1'b1, 64'd0);

    // Full scale held on every lane.
    for (int i = 0; i < 8; i++) begin
      ax_s[i] = 18'h3FFFF;
      ay_s[i] = 18'h3FFFF;
    end
    for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 1'b1, FsHand[c]);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, 64'd0);

    // Random streaming with a one-cycle reset in the middle.
    for (int c = 0; c < 1000; c++) begin
      set_rand();
      step(c == 500, 1'b1, 1'b0, 64'd0);
    end
    set_zero();
    for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 1'b0, 64'd0);

    @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
